// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the helpers used to size and decode the axis counters.
package vga_timing_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_CNT_W     = 10;

  function automatic int unsigned axis_total(input int unsigned visible, front, sync, back);
    return visible + front + sync + back;
  endfunction

  function automatic int unsigned calc_h_total(input int unsigned h_visible, h_front, h_sync, h_back);
    return axis_total(h_visible, h_front, h_sync, h_back);
  endfunction

  function automatic int unsigned calc_v_total(input int unsigned v_visible, v_front, v_sync, v_back);
    return axis_total(v_visible, v_front, v_sync, v_back);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, b);
    return (a > b) ? a : b;
  endfunction

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_window(input int unsigned pos, lo, hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from vga_timing_gen (master) to a pixel pipeline (slave); enable flows back from the consumer.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = vga_timing_pkg::VGA_CNT_W
) ();

  logic             enable;
  logic             pix_tick;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic             line_start;
  logic             frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;

  modport master (
    input  enable,
    output pix_tick, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output enable,
    input  pix_tick, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  enable,
    output pix_tick, hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pix_tick, hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis with registered sync decode; 0-cycle skew between pos and sync.
// Holds while adv is low; vis_nxt is the visible-window decode of the value pos takes at the next edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned FRONT    = VGA_H_FRONT,
  parameter int unsigned SYNC     = VGA_H_SYNC,
  parameter int unsigned BACK     = VGA_H_BACK,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned W        = VGA_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         adv,
  output logic [W-1:0] pos,
  output logic         last,
  output logic         sync,
  output logic         vis_nxt
);

  localparam int unsigned  TOTAL    = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int unsigned  SYNC_LO  = VISIBLE + FRONT;
  localparam int unsigned  SYNC_HI  = VISIBLE + FRONT + SYNC;
  localparam logic [W-1:0] LAST_POS = W'(TOTAL - 1);

  logic [W-1:0] pos_q;
  logic [W-1:0] pos_nxt;
  logic         sync_q;

  assign last = (pos_q == LAST_POS);

  always_comb begin
    pos_nxt = pos_q;
    if (adv) begin
      pos_nxt = last ? '0 : pos_q + W'(1);
    end
  end

  assign vis_nxt = (32'(pos_nxt) < VISIBLE);

  // Sync is decoded from the next position so it lands in the same cycle as pos.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q  <= '0;
      sync_q <= ~SYNC_POL;
    end else begin
      pos_q  <= pos_nxt;
      sync_q <= in_window(32'(pos_nxt), SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign pos  = pos_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk prescaler -> pixel strobe -> horizontal/vertical axis counters; positions and decodes registered together.
// enable low freezes all state and masks strobes; VGA_TIMING_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIX_DIV    = 1,
  parameter int unsigned CNT_W      = VGA_CNT_W
) (
  input logic              clk,
  input logic              reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = calc_h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = calc_v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned PRE_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PIX_DIV - 1);

  if ((64'd1 << CNT_W) < 64'(max_u(H_TOTAL, V_TOTAL))) begin : g_chk_cnt_w
    $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  if ((PIX_DIV < 1) || (PIX_DIV > 16)) begin : g_chk_pix_div
    $fatal(1, "vga_timing_gen: PIX_DIV must be in 1..16");
  end

  logic [PRE_W-1:0] presc_q;
  logic             pix_tick;

  // With PIX_DIV=1 the prescaler stays at 0 and the strobe is enable itself.
  assign pix_tick = vga.enable && (presc_q == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (vga.enable) begin
      presc_q <= pix_tick ? '0 : presc_q + PRE_W'(1);
    end
  end

  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             h_last;
  logic             v_last;
  logic             h_sync;
  logic             v_sync;
  logic             h_vis_nxt;
  logic             v_vis_nxt;
  logic             v_adv;
  logic             frame_wrap;

  assign v_adv      = pix_tick & h_last;
  assign frame_wrap = v_adv & v_last;

  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (H_SYNC_POL),
    .W        (CNT_W)
  ) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .adv      (pix_tick),
    .pos      (hpos),
    .last     (h_last),
    .sync     (h_sync),
    .vis_nxt  (h_vis_nxt)
  );

  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (V_SYNC_POL),
    .W        (CNT_W)
  ) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .adv      (v_adv),
    .pos      (vpos),
    .last     (v_last),
    .sync     (v_sync),
    .vis_nxt  (v_vis_nxt)
  );

  logic display_on_q;
  logic line_start_q;
  logic frame_start_q;

  // Pulse registers are set only by a wrapping tick, so reset release never produces one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      display_on_q  <= h_vis_nxt & v_vis_nxt;
      line_start_q  <= v_adv;
      frame_start_q <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pix_tick    = pix_tick;
  assign vga.hpos        = hpos;
  assign vga.vpos        = vpos;
  assign vga.hsync       = h_sync;
  assign vga.vsync       = v_sync;
  assign vga.display_on  = display_on_q;
  // A cycle with enable low must never show a strobe.
  assign vga.line_start  = line_start_q & vga.enable;
  assign vga.frame_start = frame_start_q & vga.enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random-enable bench for vga_timing_gen on a small raster, checked against a pixel-tick-count reference model.
// Frame counter checks are compiled in with VGA_TIMING_FRAME_CNT_EN.
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PD = 3;
  localparam int CW = 4;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(CW)) vga ();

  vga_timing_gen #(
    .H_VISIBLE  (HV),
    .H_FRONT    (HF),
    .H_SYNC     (HS),
    .H_BACK     (HB),
    .V_VISIBLE  (VV),
    .V_FRONT    (VF),
    .V_SYNC     (VS),
    .V_BACK     (VB),
    .H_SYNC_POL (HPOL),
    .V_SYNC_POL (VPOL),
    .PIX_DIV    (PD),
    .CNT_W      (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vga)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: everything follows from enabled clk count and pixel tick count.
  int en_cycles;
  int ticks;
  bit line_flag;
  bit frame_flag;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_base;
`endif

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_sync(input int p, input int lo, input int w, input bit pol);
    return ((p >= lo) && (p < lo + w)) ? pol : !pol;
  endfunction

  task automatic model_reset();
    en_cycles  = 0;
    ticks      = 0;
    line_flag  = 1'b0;
    frame_flag = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    frame_base = 16'd0;
`endif
  endtask

  task automatic model_edge(input bit en);
    line_flag  = 1'b0;
    frame_flag = 1'b0;
    if (en) begin
      if (en_cycles % PD == PD - 1) begin
        ticks++;
        line_flag  = (ticks % HT == 0);
        frame_flag = (ticks % FT == 0);
      end
      en_cycles++;
    end
  endtask

  task automatic check_all();
    int hp;
    int vp;
    hp = ticks % HT;
    vp = (ticks / HT) % VT;
    check_eq("pix_tick", longint'(vga.pix_tick), longint'(vga.enable && (en_cycles % PD == PD - 1)));
    check_eq("hpos", longint'(vga.hpos), longint'(hp));
    check_eq("vpos", longint'(vga.vpos), longint'(vp));
    check_eq("hsync", longint'(vga.hsync), longint'(m_sync(hp, HV + HF, HS, HPOL)));
    check_eq("vsync", longint'(vga.vsync), longint'(m_sync(vp, VV + VF, VS, VPOL)));
    check_eq("display_on", longint'(vga.display_on), longint'((hp < HV) && (vp < VV)));
    check_eq("line_start", longint'(vga.line_start), longint'(vga.enable && line_flag));
    check_eq("frame_start", longint'(vga.frame_start), longint'(vga.enable && frame_flag));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq("frame_cnt", longint'(vga.frame_cnt), longint'(16'(frame_base + 16'(ticks / FT))));
`endif
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_hpos"}, longint'(vga.hpos), 0);
    check_eq({tag, "_vpos"}, longint'(vga.vpos), 0);
    check_eq({tag, "_hsync"}, longint'(vga.hsync), longint'(!HPOL));
    check_eq({tag, "_vsync"}, longint'(vga.vsync), longint'(!VPOL));
    check_eq({tag, "_display_on"}, longint'(vga.display_on), 1);
    check_eq({tag, "_pix_tick"}, longint'(vga.pix_tick), 0);
    check_eq({tag, "_line_start"}, longint'(vga.line_start), 0);
    check_eq({tag, "_frame_start"}, longint'(vga.frame_start), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq({tag, "_frame_cnt"}, longint'(vga.frame_cnt), 0);
`endif
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input bit en);
    vga.enable = en;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge(en);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    int guard;
    reset_n    = 1'b1;
    vga.enable = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst_hold");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Random enable traffic.
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 3) != 0);
    end

    // Park one enabled clk before the frame wrap, then stall for 37 clk.
    guard = 0;
    while (!((ticks % FT == FT - 1) && (en_cycles % PD == PD - 1)) && (guard < 2000)) begin
      run_cycle(1'b1);
      guard++;
    end
    check_eq("park_hpos", longint'(vga.hpos), longint'(HT - 1));
    check_eq("park_vpos", longint'(vga.vpos), longint'(VT - 1));
    repeat (37) run_cycle(1'b0);
    check_eq("frozen_hpos", longint'(vga.hpos), longint'(HT - 1));
    check_eq("frozen_vpos", longint'(vga.vpos), longint'(VT - 1));
    run_cycle(1'b1);
    check_eq("wrap_hpos", longint'(vga.hpos), 0);
    check_eq("wrap_vpos", longint'(vga.vpos), 0);
    check_eq("wrap_line_start", longint'(vga.line_start), 1);
    check_eq("wrap_frame_start", longint'(vga.frame_start), 1);
    run_cycle(1'b1);
    check_eq("wrap_line_start_end", longint'(vga.line_start), 0);
    check_eq("wrap_frame_start_end", longint'(vga.frame_start), 0);

    // Continuous enable across more than two full frames.
    repeat (800) run_cycle(1'b1);

    // Asynchronous reset in mid-frame.
    guard = 0;
    while (!((ticks % HT == 5) && ((ticks / HT) % VT == 2)) && (guard < 2000)) begin
      run_cycle(1'b1);
      guard++;
    end
    check_eq("pre_rst_hpos", longint'(vga.hpos), 5);
    check_eq("pre_rst_vpos", longint'(vga.vpos), 2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("arst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("arst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_edge(vga.enable);
    #1;
    check_eq("release_line_start", longint'(vga.line_start), 0);
    check_eq("release_frame_start", longint'(vga.frame_start), 0);
    run_cycle(1'b1);
    run_cycle(1'b1);
    check_eq("post_rst_hpos", longint'(vga.hpos), 1);
    check_eq("post_rst_vpos", longint'(vga.vpos), 0);

    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 1) != 0);
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    frame_base = 16'hFFFF - 16'(ticks / FT);
    check_eq("frame_cnt_preload", longint'(vga.frame_cnt), 65535);
    @(posedge clk);
    model_edge(vga.enable);
    #1;
    guard = 0;
    while (!frame_flag && (guard < 500)) begin
      run_cycle(1'b1);
      guard++;
    end
    check_eq("frame_cnt_wrap", longint'(vga.frame_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      run_cycle(1'b1);
      while (!frame_flag && (guard < 500)) begin
        run_cycle(1'b1);
        guard++;
      end
    end
    check_eq("frame_cnt_three", longint'(vga.frame_cnt), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters H_SYNC_POL and V_SYNC_POL, default 0; 0 = sync active-low, 1 = sync active-high.
REQ-006 SHALL have parameter PIX_DIV, default 1, number of clk cycles per pixel (range 1..16).
REQ-007 SHALL have parameter CNT_W, default 10, width of hpos and vpos.
REQ-008 SHALL have ports: clk in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: enable in 1, pixel advance enable; pix_tick out 1, one-clk pixel strobe.
REQ-010 SHALL have ports: hpos out CNT_W, pixel column; vpos out CNT_W, line number.
REQ-011 SHALL have ports: hsync out 1; vsync out 1; display_on out 1, high inside the visible area.
REQ-012 SHALL have ports: line_start out 1, one-clk pulse; frame_start out 1, one-clk pulse.
REQ-013 SHALL have port frame_cnt out 16, frames completed (present only with VGA_TIMING_FRAME_CNT_EN).

Function
REQ-014 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK and V_TOTAL similarly; elaboration SHALL fail if 2^CNT_W < max(H_TOTAL, V_TOTAL) or PIX_DIV is outside 1..16.
REQ-015 Prescaler SHALL count 0..PIX_DIV-1 on clk while enable=1; pix_tick=1 when enable=1 and prescaler=PIX_DIV-1; with PIX_DIV=1, pix_tick=enable.
REQ-016 enable=0 SHALL freeze prescaler, hpos, vpos, frame_cnt and every level output; pix_tick, line_start and frame_start SHALL be 0.
REQ-017 On pix_tick, hpos SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-018 On pix_tick with hpos=H_TOTAL-1, vpos SHALL increment, wrapping from V_TOTAL-1 to 0; otherwise vpos SHALL hold.
REQ-019 All outputs SHALL be registered; hsync, vsync and display_on SHALL describe the hpos/vpos values presented in the same cycle (zero relative latency).
REQ-020 hsync SHALL be active (per H_SYNC_POL) iff H_VISIBLE+H_FRONT <= hpos < H_VISIBLE+H_FRONT+H_SYNC; vsync SHALL follow the same rule on vpos with V_* parameters.
REQ-021 display_on SHALL be 1 iff hpos < H_VISIBLE and vpos < V_VISIBLE.
REQ-022 line_start SHALL be 1 for exactly the one clk cycle in which hpos first shows 0 after a wrap; frame_start SHALL be 1 for the cycle in which hpos and vpos first both show 0 after a wrap; frame_start implies line_start.
REQ-023 Neither pulse SHALL fire on reset release.

Reset
REQ-024 reset_n low SHALL asynchronously set prescaler, hpos, vpos and frame_cnt to 0, pix_tick, line_start and frame_start to 0, hsync/vsync to their inactive levels, and display_on to 1.
REQ-025 Reset asserted mid-line or mid-frame SHALL abort the frame; the first pix_tick after release SHALL yield hpos=1, vpos=0.

Configuration
REQ-026 With macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment modulo 2^16 in the cycle frame_start is asserted; without it, the port and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package vga_timing_pkg SHALL hold the 640x480@60 default constants and the H_TOTAL/V_TOTAL calculation functions.
REQ-028 Sub-module vga_axis_counter (wrapping counter plus sync-window and visible-window decode) SHALL be instantiated once for the horizontal axis and once for the vertical axis.

Verification
REQ-029 Defaults, enable=1: hsync low for exactly 96 clk starting at hpos=656; line period 800 clk; frame period 420000 clk; vsync low while vpos is 490..491.
REQ-030 PIX_DIV=4: pix_tick every 4th clk; hpos steps once per 4 clk; line period 3200 clk.
REQ-031 Toggle enable low for 37 clk at hpos=799, vpos=524: outputs frozen, then the next pix_tick gives hpos=0, vpos=0 with line_start=frame_start=1 for one cycle.
REQ-032 H_SYNC_POL=1, V_SYNC_POL=1: sync pulses high with the same position and width; idle low from reset.
REQ-033 Assert reset_n low at hpos=300, vpos=200 with no clk edge: outputs reach reset values immediately; no pulse on release.
REQ-034 With VGA_TIMING_FRAME_CNT_EN: frame_cnt=3 after three frame_start pulses; preload 16'hFFFF by forcing, next frame gives 0.
